// File: rtl/cpu5_lsu.sv
// cpu5_lsu - load/store unit between the cpu5 datapath and the data-memory bus.
//
// Takes the datapath's single-cycle memory request (memread/memwrite, size,
// ld_unsigned, addr, wdata) and turns it into one req/ack transaction on the
// data bus. It generates byte enables and store-lane replication, extracts and
// extends load data, and holds stall high until the transaction completes.
// Misaligned accesses never reach the bus. Misaligned accesses, bus_err
// responses and ack timeouts complete with a one-cycle err pulse and rdata = 0.
//
// Ports:
//   clk, reset                       clock, synchronous active-low reset
//   memread, memwrite                load / store request, held while stall=1
//   size, ld_unsigned                access size (00 B, 01 H, 1x W), load zero-extend
//   addr, wdata                      byte address, right-aligned store data
//   rdata                            extended load data (held between completions)
//   stall                            freeze the core this cycle
//   err                              one-cycle error pulse on completion
//   bus_req, bus_we, bus_addr,
//   bus_wdata, bus_be                registered bus request side
//   bus_ack, bus_err, bus_rdata      bus response side
module cpu5_lsu #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            memread,
    input  logic            memwrite,
    input  logic [1:0]      size,
    input  logic            ld_unsigned,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] rdata,
    output logic            stall,
    output logic            err,
    output logic            bus_req,
    output logic            bus_we,
    output logic [XLEN-1:0] bus_addr,
    output logic [XLEN-1:0] bus_wdata,
    output logic [3:0]      bus_be,
    input  logic            bus_ack,
    input  logic            bus_err,
    input  logic [XLEN-1:0] bus_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam int            CW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    // Byte enables for the addressed lane(s) of the 32-bit word.
    function automatic logic [3:0] byte_en(input logic [1:0] sz, input logic [1:0] lo);
        logic [3:0] be;
        case (sz)
            2'b00:   be = 4'b0001 << lo;
            2'b01:   be = lo[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Store data copied into every lane so the enabled lane always carries it.
    function automatic logic [XLEN-1:0] replicate(input logic [1:0] sz, input logic [XLEN-1:0] wd);
        logic [XLEN-1:0] rep;
        case (sz)
            2'b00:   rep = XLEN'({4{wd[7:0]}});
            2'b01:   rep = XLEN'({2{wd[15:0]}});
            default: rep = wd;
        endcase
        return rep;
    endfunction

    // Pick the addressed byte/half out of the read word and extend it.
    function automatic logic [XLEN-1:0] load_extend(input logic [1:0] sz, input logic [1:0] lo,
                                                    input logic uns, input logic [XLEN-1:0] rd);
        logic [7:0]      b;
        logic [15:0]     h;
        logic [XLEN-1:0] r;
        b = rd[{lo, 3'b000} +: 8];
        h = rd[{lo[1], 4'b0000} +: 16];
        case (sz)
            2'b00:   r = uns ? {{(XLEN-8){1'b0}}, b}  : {{(XLEN-8){b[7]}}, b};
            2'b01:   r = uns ? {{(XLEN-16){1'b0}}, h} : {{(XLEN-16){h[15]}}, h};
            default: r = rd;
        endcase
        return r;
    endfunction

    state_t          state_r, state_s;
    logic [CW-1:0]   cnt_r, cnt_s;
    logic [1:0]      ld_size_r;
    logic [1:0]      ld_lane_r;
    logic            ld_uns_r;
    logic            bus_req_r, bus_we_r;
    logic [XLEN-1:0] bus_addr_r, bus_wdata_r;
    logic [3:0]      bus_be_r;
    logic [XLEN-1:0] rdata_r;
    logic            err_r;
    logic            op_s, misaligned_s, stall_s, done_err_s;
    logic [XLEN-1:0] ld_data_s;

    assign op_s      = memread | memwrite;
    assign rdata     = rdata_r;
    assign err       = err_r;
    assign stall     = stall_s;
    assign bus_req   = bus_req_r;
    assign bus_we    = bus_we_r;
    assign bus_addr  = bus_addr_r;
    assign bus_wdata = bus_wdata_r;
    assign bus_be    = bus_be_r;

    // Alignment check of the incoming request.
    always_comb begin
        case (size)
            2'b00:   misaligned_s = 1'b0;
            2'b01:   misaligned_s = addr[0];
            default: misaligned_s = (addr[1:0] != 2'b00);
        endcase
    end

    // Next state, stall and completion result; done_err_s/ld_data_s only
    // matter on the transition into DONE.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        stall_s    = 1'b0;
        done_err_s = 1'b0;
        ld_data_s  = {XLEN{1'b0}};
        case (state_r)
            IDLE: begin
                stall_s = op_s;
                if (op_s && misaligned_s) begin
                    state_s    = DONE;
                    done_err_s = 1'b1;
                end else if (op_s) begin
                    state_s = REQ;
                    cnt_s   = {CW{1'b0}};
                end else begin
                    state_s = IDLE;
                end
            end
            REQ: begin
                stall_s = 1'b1;
                if (bus_ack) begin
                    state_s    = DONE;
                    done_err_s = bus_err;
                    if (!bus_we_r && !bus_err) begin
                        ld_data_s = load_extend(ld_size_r, ld_lane_r, ld_uns_r, bus_rdata);
                    end else begin
                        ld_data_s = {XLEN{1'b0}};
                    end
                end else if (cnt_r == CNT_LAST) begin
                    state_s    = DONE;
                    done_err_s = 1'b1;
                end else begin
                    cnt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            DONE: begin
                // The request still held by the datapath here is the one just
                // finished, so it must not start a new access.
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, bus request registers and completion outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= IDLE;
            cnt_r       <= {CW{1'b0}};
            ld_size_r   <= 2'b00;
            ld_lane_r   <= 2'b00;
            ld_uns_r    <= 1'b0;
            bus_req_r   <= 1'b0;
            bus_we_r    <= 1'b0;
            bus_addr_r  <= {XLEN{1'b0}};
            bus_wdata_r <= {XLEN{1'b0}};
            bus_be_r    <= 4'b0000;
            rdata_r     <= {XLEN{1'b0}};
            err_r       <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            err_r   <= done_err_s;
            if (state_r != DONE && state_s == DONE) begin
                rdata_r <= ld_data_s;
            end
            if (state_r == IDLE && state_s == REQ) begin
                bus_req_r   <= 1'b1;
                bus_we_r    <= memwrite;
                bus_addr_r  <= {addr[XLEN-1:2], 2'b00};
                bus_wdata_r <= replicate(size, wdata);
                bus_be_r    <= byte_en(size, addr[1:0]);
                ld_size_r   <= size;
                ld_lane_r   <= addr[1:0];
                ld_uns_r    <= ld_unsigned;
            end else if (state_r == REQ && state_s == DONE) begin
                bus_req_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cpu5_lsu.sv
// Scoreboard bench for cpu5_lsu (TIMEOUT=4). The driver pushes the expected
// bus request and completion result for each instruction; a negedge monitor
// pops and compares when bus_req rises and when a held memory op sees stall=0.
module tb_cpu5_lsu;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        memread = 1'b0, memwrite = 1'b0, ld_unsigned = 1'b0;
    logic [1:0]  size = 2'b10;
    logic [31:0] addr = 32'd0, wdata = 32'd0;
    logic [31:0] rdata;
    logic        stall, err;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack = 1'b0, bus_err = 1'b0;
    logic [31:0] bus_rdata = 32'd0;

    cpu5_lsu #(.XLEN(32), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .memread(memread), .memwrite(memwrite),
        .size(size), .ld_unsigned(ld_unsigned), .addr(addr), .wdata(wdata),
        .rdata(rdata), .stall(stall), .err(err), .bus_req(bus_req),
        .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_be(bus_be), .bus_ack(bus_ack), .bus_err(bus_err),
        .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_t;
    typedef struct {
        int          nstall;
        int          nreq;
        logic        err;
        logic [31:0] rdata;
    } cmp_t;

    bus_t bq[$];
    cmp_t cq[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    // Bus responder: ack in the ack_k-th cycle of bus_req (0 = never).
    int          ack_k = 0;
    int          rcnt = 0;
    logic [31:0] rsp_rdata = 32'd0;
    logic        rsp_err = 1'b0;
    logic        stray = 1'b0;
    always @(negedge clk) begin
        bus_rdata = rsp_rdata;
        bus_err   = rsp_err;
        if (!reset || !bus_req) begin
            rcnt    = 0;
            bus_ack = stray;
        end else begin
            rcnt    = rcnt + 1;
            bus_ack = (rcnt == ack_k);
        end
    end

    // Monitor / scoreboard.
    int   mstall = 0, mreq = 0;
    logic req_prev = 1'b0;
    bus_t mb;
    cmp_t mc;
    always @(negedge clk) begin
        if (!reset) begin
            mstall   = 0;
            mreq     = 0;
            req_prev = 1'b0;
        end else begin
            if (bus_req && !req_prev) begin
                if (bq.size() == 0) begin
                    chk("bus_unexpected", 32'(bus_req), 32'd0);
                end else begin
                    mb = bq.pop_front();
                    chk("bus_we", 32'(bus_we), 32'(mb.we));
                    chk("bus_addr", bus_addr, mb.addr);
                    chk("bus_be", 32'(bus_be), 32'(mb.be));
                    chk("bus_wdata", bus_wdata, mb.wdata);
                end
            end
            req_prev = bus_req;
            if (bus_req) mreq++;
            if ((memread || memwrite) && stall) mstall++;
            if ((memread || memwrite) && !stall) begin
                if (cq.size() == 0) begin
                    chk("done_unexpected", 32'd1, 32'd0);
                end else begin
                    mc = cq.pop_front();
                    chk("stall_cycles", 32'(mstall), 32'(mc.nstall));
                    chk("req_cycles", 32'(mreq), 32'(mc.nreq));
                    chk("err", 32'(err), 32'(mc.err));
                    chk("rdata", rdata, mc.rdata);
                end
                mstall = 0;
                mreq   = 0;
            end else begin
                chk("err_idle", 32'(err), 32'd0);
                if (!(memread || memwrite)) chk("stall_idle", 32'(stall), 32'd0);
            end
        end
    end

    // Issue one memory instruction (called at posedge+1) and hold it to DONE.
    task automatic mem_op(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd, input int k,
                          input logic [31:0] brd, input logic berr, input logic has_bus,
                          input logic [31:0] baddr, input logic [3:0] be, input logic [31:0] bwd,
                          input int est, input int ereq, input logic eerr, input logic [31:0] erd);
        bus_t b;
        cmp_t c;
        logic done;
        b.we = wr; b.addr = baddr; b.be = be; b.wdata = bwd;
        c.nstall = est; c.nreq = ereq; c.err = eerr; c.rdata = erd;
        if (has_bus) bq.push_back(b);
        cq.push_back(c);
        ack_k = k; rsp_rdata = brd; rsp_err = berr;
        memread = rd; memwrite = wr; size = sz; ld_unsigned = uns; addr = a; wdata = wd;
        done = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (!stall) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) chk("op_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        memread = 1'b0; memwrite = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        bus_t ab;
        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_bus_req", 32'(bus_req), 32'd0);
        chk("rst_bus_we", 32'(bus_we), 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_bus_wdata", bus_wdata, 32'd0);
        chk("rst_bus_be", 32'(bus_be), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        idle(2);

        //     rd    wr    sz     uns   addr          wdata         k  bus_rdata     berr  bus   baddr         be       bwdata        st rq err   rdata
        mem_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 2, 32'h0,        1'b0, 1'b1, 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF, 3, 2, 1'b0, 32'h0);
        idle(1);
        mem_op(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0203, 32'h0,        1, 32'h80FF_1234, 1'b0, 1'b1, 32'h0000_0200, 4'b1000, 32'h0,        2, 1, 1'b0, 32'hFFFF_FF80);
        mem_op(1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0203, 32'h0,        1, 32'h80FF_1234, 1'b0, 1'b1, 32'h0000_0200, 4'b1000, 32'h0,        2, 1, 1'b0, 32'h0000_0080);
        mem_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0,        1, 32'h1111_1111, 1'b0, 1'b0, 32'h0,         4'b0000, 32'h0,        1, 0, 1'b1, 32'h0);
        idle(2);
        mem_op(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0042, 32'h0000_ABCD, 1, 32'h0,        1'b0, 1'b1, 32'h0000_0040, 4'b1100, 32'hABCD_ABCD, 2, 1, 1'b0, 32'h0);
        mem_op(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0202, 32'h0,        3, 32'h80FF_1234, 1'b0, 1'b1, 32'h0000_0200, 4'b1100, 32'h0,        4, 3, 1'b0, 32'hFFFF_80FF);
        mem_op(1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0200, 32'h0,        1, 32'h80FF_1234, 1'b0, 1'b1, 32'h0000_0200, 4'b0011, 32'h0,        2, 1, 1'b0, 32'h0000_1234);
        mem_op(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0201, 32'h0,        1, 32'h80FF_1234, 1'b0, 1'b0, 32'h0,         4'b0000, 32'h0,        1, 0, 1'b1, 32'h0);
        mem_op(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0101, 32'h0000_00A5, 1, 32'h0,        1'b0, 1'b1, 32'h0000_0100, 4'b0010, 32'hA5A5_A5A5, 2, 1, 1'b0, 32'h0);
        idle(1);
        // Timeout: bus_req exactly 4 cycles, then err.
        mem_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'h0,        0, 32'h5555_5555, 1'b0, 1'b1, 32'h0000_0300, 4'b1111, 32'h0,        5, 4, 1'b1, 32'h0);
        mem_op(1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_0308, 32'h0,        1, 32'hCAFE_F00D, 1'b0, 1'b1, 32'h0000_0308, 4'b1111, 32'h0,        2, 1, 1'b0, 32'hCAFE_F00D);
        mem_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0304, 32'h0,        1, 32'h1234_5678, 1'b1, 1'b1, 32'h0000_0304, 4'b1111, 32'h0,        2, 1, 1'b1, 32'h0);

        // Stray ack while idle must be ignored.
        idle(1);
        stray = 1'b1;
        idle(2);
        stray = 1'b0;
        idle(2);

        // Reset in the middle of REQ abandons the transaction.
        ab.we = 1'b0; ab.addr = 32'h0000_0500; ab.be = 4'b1111; ab.wdata = 32'h0;
        bq.push_back(ab);
        ack_k = 0;
        memread = 1'b1; size = 2'b10; ld_unsigned = 1'b0; addr = 32'h0000_0500; wdata = 32'h0;
        idle(2);
        reset = 1'b0; memread = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_bus_req", 32'(bus_req), 32'd0);
        chk("rst_mid_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        idle(1);
        mem_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'h0,        2, 32'h0BAD_F00D, 1'b0, 1'b1, 32'h0000_0400, 4'b1111, 32'h0,        3, 2, 1'b0, 32'h0BAD_F00D);
        idle(3);

        chk("bus_queue_empty", 32'(bq.size()), 32'd0);
        chk("cmp_queue_empty", 32'(cq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
